// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC start-pulse generator: widths, FSM states,
// and the delay-line length the TDC core is built around.
package tdc_pkg;

  localparam int TDC_CNT_W   = 16;
  localparam int TDC_BURST_W = 8;
  localparam int TDC_N_DELAY = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  // A pulse needs at least one high cycle and at least one low cycle.
  function automatic logic cfg_legal(logic [31:0] period, logic [31:0] width);
    return (width != 32'd0) && (width < period);
  endfunction

endpackage

// File: rtl/tdc_start_gen_if.sv
// Configuration, control and status bundle between a controller and the
// start-pulse generator.
interface tdc_start_gen_if
  import tdc_pkg::*;
#(
  parameter int CNT_W   = TDC_CNT_W,
  parameter int BURST_W = TDC_BURST_W
);

  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_width;
  logic [BURST_W-1:0] cfg_count;
  logic               go;
  logic               abort;
  logic               start_out;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [BURST_W-1:0] pulse_idx;

  modport master (
    output cfg_period, cfg_width, cfg_count, go, abort,
    input  start_out, busy, done, cfg_err, pulse_idx
  );

  modport slave (
    input  cfg_period, cfg_width, cfg_count, go, abort,
    output start_out, busy, done, cfg_err, pulse_idx
  );

endinterface

// File: rtl/tdc_phase_cnt.sv
// Phase counter for the start generator: counts cycles since the last rising
// edge and flags when the high-time or the period has elapsed.
module tdc_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_w_i,
  input  logic [CNT_W-1:0] cmp_p_i,
  output logic             eq_w_o,
  output logic             eq_p_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loading 1 on a rising edge makes the count equal the cycle number
  // within the pulse at each following edge.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_w_o = (cnt_q == cmp_w_i);
  assign eq_p_o = (cnt_q == cmp_p_i);

endmodule

// File: rtl/tdc_start_gen.sv
// Programmable start-pulse generator for the delay-line TDC; start_out comes
// straight from a flop so the delay line only sees clean edges.
module tdc_start_gen
  import tdc_pkg::*;
#(
  parameter int CNT_W   = TDC_CNT_W,
  parameter int BURST_W = TDC_BURST_W
) (
  input logic            clk,
  input logic            rst_n,
  tdc_start_gen_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] idx_q, idx_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cnt_load;
  logic               cnt_clr;
  logic               hit_w;
  logic               hit_p;
  logic               cfg_ok;

  assign cfg_ok = cfg_legal(32'(bus.cfg_period), 32'(bus.cfg_width));

  tdc_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cnt_load),
    .clr_i   (cnt_clr),
    .en_i    (state_q != ST_IDLE),
    .cmp_w_i (width_q),
    .cmp_p_i (period_q),
    .eq_w_o  (hit_w),
    .eq_p_o  (hit_p)
  );

  // Every output is computed one cycle ahead so it can leave on a flop.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    width_d  = width_q;
    count_d  = count_q;
    idx_d    = idx_q;
    start_d  = start_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.abort && bus.go) begin
          if (cfg_ok) begin
            period_d = bus.cfg_period;
            width_d  = bus.cfg_width;
            count_d  = bus.cfg_count;
            idx_d    = BURST_W'(1);
            start_d  = 1'b1;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            state_d  = ST_HIGH;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (bus.abort) begin
          start_d = 1'b0;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (hit_w) begin
          start_d = 1'b0;
          state_d = ST_LOW;
        end
      end

      ST_LOW: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (hit_p) begin
          // A zero burst length means run until aborted.
          if ((count_q == '0) || (idx_q < count_q)) begin
            idx_d    = idx_q + BURST_W'(1);
            start_d  = 1'b1;
            cnt_load = 1'b1;
            state_d  = ST_HIGH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        start_d = 1'b0;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      width_q  <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      width_q  <= width_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.start_out = start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;
  assign bus.pulse_idx = idx_q;

endmodule

// File: tb/tb_tdc_start_gen.sv
// Scoreboard bench for tdc_start_gen: expected per-cycle outputs come from the
// edge-placement formulas, with a narrow-index instance for wrap-around.
module tb_tdc_start_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] sb[$];
  logic [5:0]  sbNarrow[$];

  always #5 clk = ~clk;

  tdc_start_gen_if #(.CNT_W(16), .BURST_W(8)) bus1();
  tdc_start_gen_if #(.CNT_W(16), .BURST_W(2)) bus2();

  tdc_start_gen #(.CNT_W(16), .BURST_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  tdc_start_gen #(.CNT_W(16), .BURST_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  // Expected {start, busy, done, cfg_err, pulse_idx} after edge k+j, go at k.
  function automatic logic [11:0] modelObs(int j, int p, int w, int n);
    logic [11:0] r;
    if (n == 0 || j < n * p) begin
      r = {(j % p) < w, 1'b1, 1'b0, 1'b0, 8'((j / p + 1) % 256)};
    end else if (j == n * p) begin
      r = {4'b0010, 8'(n)};
    end else begin
      r = {4'b0000, 8'(n)};
    end
    return r;
  endfunction

  function automatic logic [11:0] obs1();
    return {bus1.start_out, bus1.busy, bus1.done, bus1.cfg_err, bus1.pulse_idx};
  endfunction

  function automatic logic [5:0] obs2();
    return {bus2.start_out, bus2.busy, bus2.done, bus2.cfg_err, bus2.pulse_idx};
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    logic [5:0]  got2;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = obs1();
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got=%h exp=%h", got, 12'h000);
    end
    got2 = obs2();
    checks++;
    if (got2 !== 6'h00) begin
      errors++;
      $display("[TB] FAIL reset_dut2 got=%h exp=%h", got2, 6'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [11:0] got, exp;
    bus1.cfg_period = 16'd4;
    bus1.cfg_width  = 16'd1;
    bus1.cfg_count  = 8'd1;
    for (int j = 0; j < 6; j++) sb.push_back(modelObs(j, 4, 1, 1));
    @(negedge clk);
    bus1.go = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      bus1.go = 1'b0;
      exp = sb.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL single j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_burst();
    logic [11:0] got, exp;
    int busyCycles = 0;
    bus1.cfg_period = 16'd5;
    bus1.cfg_width  = 16'd2;
    bus1.cfg_count  = 8'd3;
    for (int j = 0; j < 17; j++) sb.push_back(modelObs(j, 5, 2, 3));
    @(negedge clk);
    bus1.go = 1'b1;
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      bus1.go = 1'b0;
      exp = sb.pop_front();
      got = obs1();
      if (bus1.busy === 1'b1) busyCycles++;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL burst j=%0d got=%h exp=%h", j, got, exp);
      end
      if (j == 1) begin
        bus1.cfg_period = 16'd3;
        bus1.cfg_width  = 16'd1;
        bus1.cfg_count  = 8'd1;
      end
    end
    checks++;
    if (busyCycles != 15) begin
      errors++;
      $display("[TB] FAIL burst_busy_len got=%0d exp=%0d", busyCycles, 15);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      bus1.cfg_period = (c == 1) ? 16'd3 : 16'd4;
      bus1.cfg_width  = (c == 0) ? 16'd0 : ((c == 1) ? 16'd3 : 16'd1);
      bus1.cfg_count  = 8'd1;
      sb.push_back((c == 2) ? {4'b0000, 8'd3} : {4'b0001, 8'd3});
      sb.push_back({4'b0000, 8'd3});
      @(negedge clk);
      bus1.go    = 1'b1;
      bus1.abort = (c == 2);
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        bus1.go    = 1'b0;
        bus1.abort = 1'b0;
        exp = sb.pop_front();
        got = obs1();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL illegal case=%0d j=%0d got=%h exp=%h", c, j, got, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    bus1.cfg_period = 16'd3;
    bus1.cfg_width  = 16'd1;
    bus1.cfg_count  = 8'd2;
    for (int j = 0; j < 15; j++)
      sb.push_back((j < 7) ? modelObs(j, 3, 1, 2) : modelObs(j - 7, 3, 1, 2));
    @(negedge clk);
    bus1.go = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (j == 7) bus1.go = 1'b0;
      exp = sb.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [11:0] got, exp;
    bus1.cfg_period = 16'd6;
    bus1.cfg_width  = 16'd3;
    bus1.cfg_count  = 8'd0;
    for (int j = 0; j < 11; j++)
      sb.push_back((j < 8) ? modelObs(j, 6, 3, 0) : {4'b0000, 8'd2});
    @(negedge clk);
    bus1.go = 1'b1;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      bus1.go = 1'b0;
      exp = sb.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL abort j=%0d got=%h exp=%h", j, got, exp);
      end
      bus1.abort = (j == 7);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] got, exp;
    bus2.cfg_period = 16'd2;
    bus2.cfg_width  = 16'd1;
    bus2.cfg_count  = 2'd0;
    for (int j = 0; j < 11; j++)
      sbNarrow.push_back((j < 10) ? {(j % 2) < 1, 3'b100, 2'((j / 2 + 1) % 4)}
                                  : {4'b0000, 2'd1});
    @(negedge clk);
    bus2.go = 1'b1;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      bus2.go = (j == 3);
      exp = sbNarrow.pop_front();
      got = obs2();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL wrap j=%0d got=%h exp=%h", j, got, exp);
      end
      bus2.abort = (j == 9);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] got, exp;
    bus1.cfg_period = 16'd6;
    bus1.cfg_width  = 16'd3;
    bus1.cfg_count  = 8'd0;
    sb.push_back(modelObs(0, 6, 3, 0));
    @(negedge clk);
    bus1.go = 1'b1;
    @(negedge clk);
    bus1.go = 1'b0;
    exp = sb.pop_front();
    got = obs1();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL async_pre got=%h exp=%h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1 got = obs1();
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("[TB] FAIL async_immediate got=%h exp=%h", got, 12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = obs1();
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("[TB] FAIL async_idle got=%h exp=%h", got, 12'h000);
    end
    bus1.cfg_period = 16'd4;
    bus1.cfg_width  = 16'd1;
    bus1.cfg_count  = 8'd1;
    for (int j = 0; j < 6; j++) sb.push_back(modelObs(j, 4, 1, 1));
    bus1.go = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      bus1.go = 1'b0;
      exp = sb.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL async_restart j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  initial begin
    bus1.cfg_period = '0;
    bus1.cfg_width  = '0;
    bus1.cfg_count  = '0;
    bus1.go         = 1'b0;
    bus1.abort      = 1'b0;
    bus2.cfg_period = '0;
    bus2.cfg_width  = '0;
    bus2.cfg_count  = '0;
    bus2.go         = 1'b0;
    bus2.abort      = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_start_gen.md
# tdc_start_gen

Programmable start-pulse transmitter for the delay-line TDC. It generates the `start` edge train that the TDC front end samples, with a programmable period, high-time and burst length, all counted in `clk` cycles. The output is driven from a single flop so that the delay line only ever sees glitch-free edges. The block sits beside the TDC top level and drives its start input, on-chip or through a pad.

## Interface

**Parameters**
- `CNT_W`, default 16: width of the period and high-time counters.
- `BURST_W`, default 8: width of the burst-length field and the pulse index.

**Ports**
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cfg_period`  in  CNT_W: pulse period P, in cycles.
- `cfg_width`  in  CNT_W: high-time W, in cycles.
- `cfg_count`  in  BURST_W: burst length N; 0 means continuous.
- `go`  in  1: request to start a burst; sampled only in IDLE.
- `abort`  in  1: stop immediately; has priority over `go`.
- `start_out`  out  1: registered start edge to the TDC.
- `busy`  out  1: high while a burst is running.
- `done`  out  1: one-cycle pulse when a burst completes normally.
- `cfg_err`  out  1: one-cycle pulse when `go` arrives with an illegal configuration.
- `pulse_idx`  out  BURST_W: number of rising edges emitted in the current burst.

## Operation

**Reset values**
- All outputs are 0 and the state is IDLE.
- Reset takes effect asynchronously, so `start_out` falls immediately, even mid-pulse.

**States:** IDLE, HIGH, LOW.

**IDLE**
- `go` with a legal configuration: latch P, W and N, clear `pulse_idx`, go to HIGH, set `start_out` to 1, set `busy` to 1, set `pulse_idx` to 1.
- Legal configuration: W ≥ 1 and W < P, which forces P ≥ 2.
- `go` with an illegal configuration: `cfg_err` pulses for one cycle, the block stays in IDLE, no edge is emitted.
- `go` and `abort` in the same cycle: `abort` wins, so nothing happens.

**HIGH**
- The phase counter runs from the rising edge.
- After W cycles: go to LOW and clear `start_out`.

**LOW**
- When the phase counter reaches P:
  - If N = 0, or `pulse_idx` < N: go to HIGH, set `start_out`, increment `pulse_idx`.
  - Otherwise: go to IDLE, clear `busy`, pulse `done`.

**Continuous mode (N = 0)**
- `pulse_idx` wraps from 2^BURST_W − 1 to 0.
- The burst runs until `abort`.

**abort**
- In HIGH or LOW: on the next edge go to IDLE, clear `start_out` and `busy`.
- No `done` pulse; `pulse_idx` holds its last value.

**Other rules**
- `go` is ignored while `busy` is high.
- Configuration changes after latching have no effect until the next `go`.

## Timing

**Edge placement**, with `go` sampled at clock edge k:
- `start_out` rises after edges k + n·P, for n = 0 … N−1.
- `start_out` falls after edges k + n·P + W.

**Burst completion:**
- `done` is high for the single cycle after edge k + N·P.
- `busy` is low from that same edge.
- `go` is accepted from the cycle after `done`, so the minimum gap between bursts is one idle cycle.

**Output latency:** one clock from `go` to the first edge. No combinational path from any input to `start_out`.

**Worked example:** P = 4, W = 1, N = 2, `go` sampled at edge 10.
- `start_out` is 1 after edges 10 and 14, and 0 after edges 11 and 15.
- `done` is high after edge 18.
- `busy` is high after edges 10 through 17.

**Phase counter**
- CNT_W bits wide; it saturates cannot occur, because P ≤ 2^CNT_W − 1.
- Comparisons are unsigned.

## Structure

**Package `tdc_pkg`**
- State enum: IDLE, HIGH, LOW.
- Default `CNT_W` and `BURST_W`.
- A shared `TDC_N_DELAY` constant, so that the TDC and this generator agree on the measurable range.

**Sub-module `tdc_phase_cnt`**
- Loadable up-counter with clear and compare outputs for W and P.
- Instantiated once.
- The FSM stays in the top module.

## Test plan

- **Single pulse:** P = 4, W = 1, N = 1, `go` at edge 10 → `start_out` high for 1 cycle after edge 10; `done` after edge 14; `pulse_idx` = 1.
- **Burst:** P = 5, W = 2, N = 3 → three edges 5 cycles apart, each 2 cycles high; `done` 15 cycles after `go`; `busy` high for exactly 15 cycles.
- **Illegal configuration:**
  - W = 0 → `cfg_err` pulses, `busy` stays 0, `start_out` stays 0.
  - W = P = 3 → same response.
- **Abort mid-pulse:** N = 0, P = 6, W = 3; `abort` during the second HIGH → `start_out` and `busy` are 0 after the next edge; no `done`; `pulse_idx` = 2.
- **Continuous wrap:** BURST_W = 2, N = 0 → `pulse_idx` sequence 1, 2, 3, 0, 1; a `go` while busy is ignored.
- **Async reset:** assert `rst_n` = 0 mid-HIGH, between clock edges → `start_out` is 0 immediately; after release the block is in IDLE and a new `go` is accepted.
